// File: rtl/extensiondesigno_pipe.sv
// extensiondesigno_pipe
// Pipelined RV32I/RV64I immediate generator for the decode path.
// Each accepted instruction is decoded into {immediate, format, illegal flag, raw
// word} and queued in a DEPTH-entry FIFO. Fetch and execute can therefore stall
// independently of each other.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   valido_i       upstream offers instruccion_i
//   listo_o        FIFO has room (registered state only)
//   instruccion_i  raw 32-bit instruction word
//   valido_o       head entry valid
//   listo_i        downstream takes the head entry
//   inmediato_o    sign-extended immediate of the head entry (XLEN bits)
//   tipo_o         head format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
//   ilegal_o       head opcode unsupported
//   instruccion_o  head entry's original word
//   ocupacion_o    number of stored entries
module extensiondesigno_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valido_i,
    output logic                         listo_o,
    input  logic [31:0]                  instruccion_i,
    output logic                         valido_o,
    input  logic                         listo_i,
    output logic [XLEN-1:0]              inmediato_o,
    output logic [2:0]                   tipo_o,
    output logic                         ilegal_o,
    output logic [31:0]                  instruccion_o,
    output logic [$clog2(DEPTH+1)-1:0]   ocupacion_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [2:0] TIPO_R   = 3'd0;
    localparam logic [2:0] TIPO_I   = 3'd1;
    localparam logic [2:0] TIPO_S   = 3'd2;
    localparam logic [2:0] TIPO_B   = 3'd3;
    localparam logic [2:0] TIPO_U   = 3'd4;
    localparam logic [2:0] TIPO_J   = 3'd5;
    localparam logic [2:0] TIPO_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      tipo;
        logic            ilegal;
        logic [31:0]     inst;
    } entry_t;

    // Build the 32-bit immediate per format, then widen it from its own MSB.
    // Extending from imm32[31] instead of inst[31] keeps R/illegal at zero
    // even when inst[31] is set.
    function automatic entry_t decode(input logic [31:0] inst);
        entry_t      e;
        logic [31:0] imm32;
        logic [63:0] imm64;
        imm32    = 32'd0;
        e.tipo   = TIPO_ILL;
        e.ilegal = 1'b1;
        case (inst[6:0])
            7'b0110011: begin
                e.tipo = TIPO_R; e.ilegal = 1'b0; imm32 = 32'd0;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.tipo = TIPO_I; e.ilegal = 1'b0;
                imm32  = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                e.tipo = TIPO_S; e.ilegal = 1'b0;
                imm32  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                e.tipo = TIPO_B; e.ilegal = 1'b0;
                imm32  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                e.tipo = TIPO_U; e.ilegal = 1'b0;
                imm32  = {inst[31:12], 12'd0};
            end
            7'b1101111: begin
                e.tipo = TIPO_J; e.ilegal = 1'b0;
                imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                e.tipo = TIPO_ILL; e.ilegal = 1'b1; imm32 = 32'd0;
            end
        endcase
        imm64  = {{32{imm32[31]}}, imm32};
        e.imm  = imm64[XLEN-1:0];
        e.inst = inst;
        return e;
    endfunction

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    entry_t             entry_s;
    entry_t             head_s;
    logic               push_s;
    logic               pop_s;
    logic               listo_s;
    logic               valido_s;

    assign entry_s  = decode(instruccion_i);
    assign listo_s  = (occ_q < OCC_W'(DEPTH));
    assign valido_s = (occ_q != {OCC_W{1'b0}});
    // Push and pop use only registered fullness, so a pop on a full FIFO does not free a slot this cycle.
    assign push_s   = valido_i & listo_s;
    assign pop_s    = valido_s & listo_i;
    assign head_s   = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            occ_q    <= {OCC_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= entry_s;
            end
        end
    end

    // Head outputs, forced to zero while the FIFO is empty.
    always_comb begin
        inmediato_o   = {XLEN{1'b0}};
        tipo_o        = 3'd0;
        ilegal_o      = 1'b0;
        instruccion_o = 32'd0;
        if (valido_s) begin
            inmediato_o   = head_s.imm;
            tipo_o        = head_s.tipo;
            ilegal_o      = head_s.ilegal;
            instruccion_o = head_s.inst;
        end else begin
            inmediato_o   = {XLEN{1'b0}};
        end
    end

    assign listo_o     = listo_s;
    assign valido_o    = valido_s;
    assign ocupacion_o = occ_q;

endmodule

// File: tb/tb_extensiondesigno_pipe.sv
module tb_extensiondesigno_pipe;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valido_i;
    logic [31:0] instruccion_i;
    logic        listo_i;

    logic        listo_o, valido_o, ilegal_o;
    logic [31:0] inm32, instruccion_o;
    logic [2:0]  tipo_o;
    logic [1:0]  ocup;

    logic        listo64, valido64, ilegal64;
    logic [63:0] inm64;
    logic [31:0] inst64;
    logic [2:0]  tipo64;
    logic [1:0]  ocup64;

    int total = 0;
    int bad   = 0;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    extensiondesigno_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .valido_i(valido_i), .listo_o(listo_o),
        .instruccion_i(instruccion_i), .valido_o(valido_o), .listo_i(listo_i),
        .inmediato_o(inm32), .tipo_o(tipo_o), .ilegal_o(ilegal_o),
        .instruccion_o(instruccion_o), .ocupacion_o(ocup));

    extensiondesigno_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk_i(clk), .rst_ni(rst_ni), .valido_i(valido_i), .listo_o(listo64),
        .instruccion_i(instruccion_i), .valido_o(valido64), .listo_i(listo_i),
        .inmediato_o(inm64), .tipo_o(tipo64), .ilegal_o(ilegal64),
        .instruccion_o(inst64), .ocupacion_o(ocup64));

    // Reference decode: immediate value as a signed integer built from field weights.
    function automatic void ref_decode(input logic [31:0] w, output logic [63:0] imm,
                                       output logic [2:0] tipo, output logic ileg);
        longint v;
        longint s;
        s    = w[31] ? 64'sd1 : 64'sd0;
        v    = 64'sd0;
        tipo = 3'd7;
        ileg = 1'b1;
        case (w[6:0])
            7'b0110011: begin tipo = 3'd0; ileg = 1'b0; v = 64'sd0; end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                tipo = 3'd1; ileg = 1'b0;
                v = longint'(w[31:20]) - s * 64'sd4096;
            end
            7'b0100011: begin
                tipo = 3'd2; ileg = 1'b0;
                v = longint'(w[31:25]) * 64'sd32 + longint'(w[11:7]) - s * 64'sd4096;
            end
            7'b1100011: begin
                tipo = 3'd3; ileg = 1'b0;
                v = longint'(w[7]) * 64'sd2048 + longint'(w[30:25]) * 64'sd32
                  + longint'(w[11:8]) * 64'sd2 - s * 64'sd4096;
            end
            7'b0110111, 7'b0010111: begin
                tipo = 3'd4; ileg = 1'b0;
                v = longint'(w[31:12]) * 64'sd4096 - s * 64'sd4294967296;
            end
            7'b1101111: begin
                tipo = 3'd5; ileg = 1'b0;
                v = longint'(w[19:12]) * 64'sd4096 + longint'(w[20]) * 64'sd2048
                  + longint'(w[30:21]) * 64'sd2 - s * 64'sd1048576;
            end
            default: begin tipo = 3'd7; ileg = 1'b1; v = 64'sd0; end
        endcase
        imm = v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the queue model.
    task automatic check_outputs();
        logic [63:0] imm;
        logic [2:0]  t;
        logic        il;
        logic [31:0] head;
        imm = 64'd0; t = 3'd0; il = 1'b0; head = 32'd0;
        if (mq.size() != 0) begin
            head = mq[0];
            ref_decode(head, imm, t, il);
        end
        chk("valido",   {63'd0, valido_o}, {63'd0, mq.size() != 0});
        chk("listo",    {63'd0, listo_o},  {63'd0, mq.size() < DEPTH});
        chk("ocup",     {62'd0, ocup},     64'(mq.size()));
        chk("imm32",    {32'd0, inm32},    {32'd0, imm[31:0]});
        chk("tipo",     {61'd0, tipo_o},   {61'd0, t});
        chk("ilegal",   {63'd0, ilegal_o}, {63'd0, il});
        chk("inst",     {32'd0, instruccion_o}, {32'd0, head});
        chk("imm64",    inm64,             imm);
        chk("valido64", {63'd0, valido64}, {63'd0, mq.size() != 0});
        chk("ocup64",   {62'd0, ocup64},   64'(mq.size()));
    endtask

    // One cycle: check at negedge, drive, advance model at posedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy);
        logic push, pop;
        check_outputs();
        valido_i = v; instruccion_i = ins; listo_i = rdy;
        push = v && (mq.size() < DEPTH);
        pop  = (mq.size() != 0) && rdy;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(ins);
        @(negedge clk);
    endtask

    logic [31:0] d_inst [8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h001000EF,
                                32'h123452B7, 32'h800002B7, 32'h0000007F, 32'h002081B3};
    logic [63:0] d_imm  [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                64'h0000000000000800, 64'h0000000012345000, 64'hFFFFFFFF80000000,
                                64'h0, 64'h0};
    logic [2:0]  d_tipo [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd4, 3'd7, 3'd0};
    logic [6:0]  ops    [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};

    initial begin
        logic [31:0] r;
        logic [63:0] imm32e;
        rst_ni = 1'b0; valido_i = 1'b0; instruccion_i = 32'd0; listo_i = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst_ni = 1'b1;

        // Spec examples, one at a time, with explicit constants.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, d_inst[i], 1'b0);
            imm32e = {32'd0, d_imm[i][31:0]};
            chk("dir_valido", {63'd0, valido_o}, 64'd1);
            chk("dir_imm32",  {32'd0, inm32}, imm32e);
            chk("dir_imm64",  inm64, d_imm[i]);
            chk("dir_tipo",   {61'd0, tipo_o}, {61'd0, d_tipo[i]});
            chk("dir_ilegal", {63'd0, ilegal_o}, {63'd0, d_tipo[i] == 3'd7});
            chk("dir_inst",   {32'd0, instruccion_o}, {32'd0, d_inst[i]});
            step(1'b0, 32'd0, 1'b1);
        end

        // Ordering: four pushes back-to-back with draining.
        for (int i = 0; i < 4; i++) step(1'b1, d_inst[i], 1'b1);
        repeat (3) step(1'b0, 32'd0, 1'b1);

        // Fill to full with downstream stalled; third is held.
        step(1'b1, d_inst[0], 1'b0);
        step(1'b1, d_inst[1], 1'b0);
        chk("full_listo", {63'd0, listo_o}, 64'd0);
        chk("full_ocup",  {62'd0, ocup}, 64'd2);
        step(1'b1, d_inst[2], 1'b0);
        chk("held_ocup",  {62'd0, ocup}, 64'd2);
        chk("held_head",  {32'd0, instruccion_o}, {32'd0, d_inst[0]});
        step(1'b1, d_inst[2], 1'b1);          // pop only, full blocks push
        chk("after_pop_ocup", {62'd0, ocup}, 64'd1);
        step(1'b1, d_inst[2], 1'b1);          // third accepted now
        for (int i = 3; i < 8; i++) step(1'b1, d_inst[i], 1'b1);
        repeat (3) step(1'b0, 32'd0, 1'b1);

        // Reset between edges with two entries stored.
        step(1'b1, d_inst[4], 1'b0);
        step(1'b1, d_inst[5], 1'b0);
        chk("pre_rst_ocup", {62'd0, ocup}, 64'd2);
        #2;
        rst_ni = 1'b0; valido_i = 1'b1; instruccion_i = d_inst[0];
        #1;
        mq.delete();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_ni = 1'b1;
        step(1'b1, 32'h00A00113, 1'b0);
        chk("post_rst_inst", {32'd0, instruccion_o}, 64'h00A00113);
        step(1'b0, 32'd0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int sel;
            r = $urandom();
            sel = $urandom_range(0, 10);
            if (sel < 10) r = {r[31:7], ops[sel]};
            step(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 3) != 0));
        end
        repeat (3) step(1'b0, 32'd0, 1'b1);
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/extensiondesigno_pipe.md
Name: extensiondesigno_pipe

Overview:
- Parametrised, pipelined immediate generator for the core's decode path.
- Decodes all RV32I/RV64I immediate formats (I, S, B, U, J, R) and sign-extends the immediate to XLEN.
- Tags each instruction with its format and an illegal-opcode flag.
- Buffers results in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so fetch and execute can stall independently.

Parameters:
- XLEN, 32, width of the immediate output; legal values 32 or 64.
- DEPTH, 2, number of output FIFO entries, 1..8; need not be a power of two.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- valido_i  input  1  upstream has an instruction on instruccion_i.
- listo_o  output  1  block can accept an instruction this cycle.
- instruccion_i  input  32  raw instruction word.
- valido_o  output  1  head FIFO entry is valid.
- listo_i  input  1  downstream accepts the head entry this cycle.
- inmediato_o  output  XLEN  sign-extended immediate of the head entry.
- tipo_o  output  3  format of the head entry: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- ilegal_o  output  1  head entry opcode is unsupported.
- instruccion_o  output  32  head entry's original instruction word.
- ocupacion_o  output  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Opcode to format mapping:
  - Opcode 0110011 is R; immediate 0.
  - Opcodes 0010011, 0000011, 1100111 are I; immediate sext(inst[31:20]).
  - Opcode 0100011 is S; immediate sext({inst[31:25], inst[11:7]}).
  - Opcode 1100011 is B; immediate sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - Opcodes 0110111 and 0010111 are U; immediate sext({inst[31:12], 12'b0}).
  - Opcode 1101111 is J; immediate sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Any other opcode is illegal: tipo 7, ilegal 1, immediate 0.
- All sign extension replicates inst[31] up to bit XLEN-1.
- Decode is combinational on instruccion_i. The decoded entry {immediate, tipo, ilegal, instruccion} is written into the FIFO.
- Push occurs when valido_i && listo_o. Pop occurs when valido_o && listo_i.
- listo_o = (ocupacion_o < DEPTH). It depends only on registered state, with no combinational path from listo_i. When full, a same-cycle pop does not enable a push.
- valido_o = (ocupacion_o != 0).
- Latency: an instruction accepted at edge N appears on the outputs after edge N. If no other entries are ahead, valido_o is 1 in the cycle following edge N.
- Ordering is strict FIFO. Head outputs are stable while valido_o && !listo_i.
- Simultaneous push and pop, when not full and not empty: occupancy is unchanged and both pointers advance.
- Push into an empty FIFO with listo_i=1: the entry is not popped in the same cycle; it is visible the next cycle.
- Read and write pointers wrap from DEPTH-1 to 0.
- When empty: inmediato_o, tipo_o, ilegal_o and instruccion_o are driven to 0.
- Reset (rst_ni=0), including mid-operation:
  - Immediately clears pointers and occupancy; all stored entries are discarded.
  - Outputs go to valido_o=0, listo_o=1, ocupacion_o=0, and all data outputs 0.
  - No push occurs while rst_ni=0.
- Push while valido_i=0, or pop while valido_o=0, has no effect.

Test Plan:
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) -> next cycle valido_o=1, inmediato_o=0xFFFFFFFF, tipo_o=1, ilegal_o=0, instruccion_o=0xFFF00093.
- Push 0xFE112E23 (sw x1,-4(x2)) -> 0xFFFFFFFC, tipo 2. Push 0xFE000CE3 (beq x0,x0,-8) -> 0xFFFFFFF8, tipo 3. Push 0x001000EF (jal x1,+2048) -> 0x00000800, tipo 5. All are popped in push order.
- XLEN=32, push 0x123452B7 (lui x5,0x12345) -> 0x12345000, tipo 4. With XLEN=64, push 0x800002B7 -> 0xFFFFFFFF80000000, tipo 4.
- Push 0x0000007F -> tipo_o=7, ilegal_o=1, inmediato_o=0. Push 0x002081B3 (add) -> tipo 0, immediate 0.
- DEPTH=2, listo_i=0, offer 3 instructions back-to-back -> listo_o falls after 2 accepts, ocupacion_o=2, third is held upstream. Raise listo_i -> entries drain in order; third accepted the cycle after the first pop; continuous push and pop sustains 1 instruction per cycle.
- With 2 entries stored, assert rst_ni=0 between edges -> valido_o=0 and ocupacion_o=0 immediately. After release, the first new push emerges with no stale data.
